// File: rtl/pkt_pkg.sv
// Shared packet field layout, packet types and ingress FSM states.
// Pure declarations: no latency, no backpressure.
package pkt_pkg;

  localparam int PKT_W    = 13;
  localparam int ADDR_MSB = 12;
  localparam int ADDR_LSB = 11;
  localparam int TYPE_MSB = 10;
  localparam int TYPE_LSB = 9;
  localparam int PAY_MSB  = 8;
  localparam int PAY_LSB  = 1;
  localparam int EOF_BIT  = 0;

  typedef enum logic [1:0] {
    PKT_DATA = 2'b00,
    PKT_CTRL = 2'b01,
    PKT_RESP = 2'b10,
    PKT_ILL  = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FRAME = 2'b01,
    DROP  = 2'b10
  } ingress_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Count reflects an increment one cycle after inc_i; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/packet_ingress_ctrl.sv
// Ingress framer: type-checks and frames beats, forwards legal ones one cycle later.
// in_ready is simply !stall; dropped frames are discarded up to their EOF beat.
module packet_ingress_ctrl
  import pkt_pkg::*;
#(
  parameter int MAX_FRAME = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_packet,
  input  logic             stall,
  output logic [PKT_W-1:0] out_packet,
  output logic             data_valid,
  output logic             ctrl_valid,
  output logic             resp_valid,
  output logic             frame_done,
  output logic             drop_err,
  output logic [CNT_W-1:0] cnt_data,
  output logic [CNT_W-1:0] cnt_ctrl,
  output logic [CNT_W-1:0] cnt_resp
);

  localparam int BEAT_W = $clog2(MAX_FRAME + 1);
  localparam logic [BEAT_W-1:0] LAST_OPEN_BEAT = BEAT_W'(MAX_FRAME - 1);

  ingress_state_e    state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  pkt_type_e         locked_type_q, locked_type_d;
  logic [PKT_W-1:0]  out_packet_q;
  logic              data_valid_q, ctrl_valid_q, resp_valid_q;
  logic              frame_done_q, drop_err_q;

  logic      accept;
  logic      eof;
  pkt_type_e pkt_type;
  logic      fwd;
  logic      drop;
  logic      inc_data, inc_ctrl, inc_resp;

  assign in_ready = !stall;
  assign accept   = in_valid && !stall;
  assign eof      = in_packet[EOF_BIT];
  assign pkt_type = pkt_type_e'(in_packet[TYPE_MSB:TYPE_LSB]);

  always_comb begin
    fwd           = 1'b0;
    drop          = 1'b0;
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    locked_type_d = locked_type_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (pkt_type == PKT_ILL) begin
            drop    = 1'b1;
            state_d = eof ? IDLE : DROP;
          end else begin
            fwd           = 1'b1;
            locked_type_d = pkt_type;
            beat_cnt_d    = BEAT_W'(1);
            state_d       = eof ? IDLE : FRAME;
          end
        end
        FRAME: begin
          // locked_type is never PKT_ILL, so an illegal beat lands in the mismatch branch
          if (pkt_type != locked_type_q) begin
            drop    = 1'b1;
            state_d = eof ? IDLE : DROP;
          end else if (eof) begin
            fwd     = 1'b1;
            state_d = IDLE;
          end else if (beat_cnt_q == LAST_OPEN_BEAT) begin
            drop    = 1'b1;
            state_d = DROP;
          end else begin
            fwd        = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        DROP: begin
          if (eof) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign inc_data = fwd && (pkt_type == PKT_DATA);
  assign inc_ctrl = fwd && (pkt_type == PKT_CTRL);
  assign inc_resp = fwd && (pkt_type == PKT_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      locked_type_q <= PKT_DATA;
      out_packet_q  <= '0;
      data_valid_q  <= 1'b0;
      ctrl_valid_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      locked_type_q <= locked_type_d;
      data_valid_q  <= inc_data;
      ctrl_valid_q  <= inc_ctrl;
      resp_valid_q  <= inc_resp;
      frame_done_q  <= fwd && eof;
      drop_err_q    <= drop;
      if (fwd) out_packet_q <= in_packet;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_data (.clk(clk), .rst(rst), .inc_i(inc_data), .cnt_o(cnt_data));
  sat_counter #(.W(CNT_W)) u_cnt_ctrl (.clk(clk), .rst(rst), .inc_i(inc_ctrl), .cnt_o(cnt_ctrl));
  sat_counter #(.W(CNT_W)) u_cnt_resp (.clk(clk), .rst(rst), .inc_i(inc_resp), .cnt_o(cnt_resp));

  assign out_packet = out_packet_q;
  assign data_valid = data_valid_q;
  assign ctrl_valid = ctrl_valid_q;
  assign resp_valid = resp_valid_q;
  assign frame_done = frame_done_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_packet_ingress_ctrl.sv
// Directed bench: default-parameter instance plus a MAX_FRAME=4 / CNT_W=2 instance.
module tb_packet_ingress_ctrl;
  import pkt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // instance 0: defaults
  logic        v0 = 1'b0, s0 = 1'b0, rdy0;
  logic [12:0] p0 = '0, o0;
  logic        dv0, cv0, rv0, fd0, de0;
  logic [15:0] cd0, cc0, cr0;

  // instance 1: short frames, 2-bit counters
  logic        v1 = 1'b0, s1 = 1'b0, rdy1;
  logic [12:0] p1 = '0, o1;
  logic        dv1, cv1, rv1, fd1, de1;
  logic [1:0]  cd1, cc1, cr1;

  packet_ingress_ctrl dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_packet(p0), .stall(s0),
    .out_packet(o0), .data_valid(dv0), .ctrl_valid(cv0), .resp_valid(rv0),
    .frame_done(fd0), .drop_err(de0), .cnt_data(cd0), .cnt_ctrl(cc0), .cnt_resp(cr0)
  );

  packet_ingress_ctrl #(.MAX_FRAME(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_packet(p1), .stall(s1),
    .out_packet(o1), .data_valid(dv1), .ctrl_valid(cv1), .resp_valid(rv1),
    .frame_done(fd1), .drop_err(de1), .cnt_data(cd1), .cnt_ctrl(cc1), .cnt_resp(cr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input logic [1:0] addr, input logic [1:0] typ,
                                     input logic [7:0] pay, input logic eof);
    return {addr, typ, pay, eof};
  endfunction

  // Present one beat for one edge; outputs for it are sampled 1 time unit later.
  task automatic send(input int sel, input logic [12:0] pkt);
    if (sel == 0) begin v0 = 1'b1; p0 = pkt; end
    else          begin v1 = 1'b1; p1 = pkt; end
    @(posedge clk); #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [12:0] pkt;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_out", o0, 13'h0);
    check("rst_valids", {dv0, cv0, rv0, fd0, de0}, 5'b0);
    check("rst_cnts", {cd0, cc0, cr0}, 48'h0);
    check("rst_ready", rdy0, 1'b1);

    // single-beat DATA
    send(0, mk(2'd2, 2'b00, 8'hA5, 1'b1));
    check("data_out", o0, 13'h114B);
    check("data_valids", {dv0, cv0, rv0}, 3'b100);
    check("data_fd", fd0, 1'b1);
    check("data_cnt", cd0, 16'd1);
    idle_cycle();
    check("data_clr", {dv0, fd0, de0}, 3'b000);
    check("data_hold", o0, 13'h114B);

    // 3-beat CTRL frame
    for (int i = 0; i < 3; i++) begin
      pkt = mk(2'd1, 2'b01, 8'(8'h11 * (i + 1)), (i == 2));
      send(0, pkt);
      check("ctrl_valids", {dv0, cv0, rv0}, 3'b010);
      check("ctrl_out", o0, pkt);
      check("ctrl_fd", fd0, (i == 2));
    end
    check("ctrl_cnt", cc0, 16'd3);
    check("ctrl_state", dut0.state_q, IDLE);

    // RESP frame with a type mismatch on beat 2
    send(0, mk(2'd3, 2'b10, 8'h01, 1'b0));
    check("resp_b1", {dv0, cv0, rv0, de0}, 4'b0010);
    send(0, mk(2'd3, 2'b00, 8'h02, 1'b0));
    check("resp_b2", {dv0, cv0, rv0, de0}, 4'b0001);
    send(0, mk(2'd3, 2'b10, 8'h03, 1'b1));
    check("resp_b3", {dv0, cv0, rv0, fd0, de0}, 5'b00000);
    check("resp_cnt", cr0, 16'd1);
    check("resp_cnt_data", cd0, 16'd1);

    // illegal type in IDLE, then a normal DATA beat
    send(0, mk(2'd0, 2'b11, 8'hFF, 1'b1));
    check("ill_b", {dv0, cv0, rv0, fd0, de0}, 5'b00001);
    idle_cycle();
    check("ill_clr", de0, 1'b0);
    pkt = mk(2'd0, 2'b00, 8'h3C, 1'b1);
    send(0, pkt);
    check("ill_next_out", o0, pkt);
    check("ill_next_dv", {dv0, de0}, 2'b10);
    check("ill_next_cnt", cd0, 16'd2);

    // stall blocks acceptance
    s0 = 1'b1;
    send(0, mk(2'd1, 2'b00, 8'h77, 1'b1));
    check("stall_ready", rdy0, 1'b0);
    check("stall_dv", dv0, 1'b0);
    check("stall_cnt", cd0, 16'd2);
    s0 = 1'b0;
    #1 check("stall_release", rdy0, 1'b1);

    // reset mid-frame
    send(0, mk(2'd1, 2'b01, 8'h55, 1'b0));
    check("mid_ctrl", cv0, 1'b1);
    do_reset();
    check("mid_rst_out", o0, 13'h0);
    check("mid_rst_flags", {dv0, cv0, rv0, fd0, de0}, 5'b0);
    check("mid_rst_cnts", {cd0, cc0, cr0}, 48'h0);
    pkt = mk(2'd2, 2'b00, 8'h99, 1'b1);
    send(0, pkt);
    check("mid_after_dv", {dv0, de0, fd0}, 3'b101);
    check("mid_after_cnt", cd0, 16'd1);

    // overrun on the MAX_FRAME=4 instance
    for (int i = 0; i < 5; i++) begin
      send(1, mk(2'd0, 2'b00, 8'(i), 1'b0));
      check("ovr_dv", dv1, (i < 3));
      check("ovr_de", de1, (i == 3));
    end
    send(1, mk(2'd0, 2'b00, 8'hEE, 1'b1));
    check("ovr_eof", {dv1, fd1, de1}, 3'b000);
    check("ovr_cnt", cd1, 2'd3);
    check("ovr_state", dut1.state_q, IDLE);

    // saturation of the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send(1, mk(2'd1, 2'b00, 8'h40, 1'b1));
      check("sat_dv", dv1, 1'b1);
      check("sat_cnt", cd1, 2'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
